// File: rtl/gpo_blink.sv
// Per-channel LED driver: steady, slow/fast blink or one-shot pulse, CSR programmable.
// Optional output polarity register is enabled by defining GPO_BLINK_POL_EN.
module gpo_blink #(
  parameter logic [4:0]  BASE_ADDR = 5'h0,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned TICK_DIV  = 32768
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        csr_a,
  input  logic [7:0]        csr_di,
  input  logic              csr_we,
  output logic [7:0]        csr_do,
  input  logic [NUM_CH-1:0] en,
  output logic [NUM_CH-1:0] led
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam int unsigned   MW       = 2 * NUM_CH;
  localparam logic [PW-1:0] CNT_MAX  = PW'(TICK_DIV - 1);
  localparam logic [4:0]    POL_ADDR = BASE_ADDR + 5'd1;

  logic [PW-1:0]           cnt_q,   cnt_d;
  logic [3:0]              phase_q, phase_d;
  logic [MW-1:0]           mode_q,  mode_d;
  logic [NUM_CH-1:0]       en_q;
  logic [NUM_CH-1:0][2:0]  pcnt_q,  pcnt_d;
  logic [NUM_CH-1:0]       led_q,   led_d;
  logic                    tick_c;
  logic                    mode_wr_c;
`ifdef GPO_BLINK_POL_EN
  logic [NUM_CH-1:0]       pol_q,   pol_d;
`endif

  assign led = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= '0;
      mode_q  <= '0;
      en_q    <= '0;
      pcnt_q  <= '0;
      led_q   <= '0;
`ifdef GPO_BLINK_POL_EN
      pol_q   <= '0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
      en_q    <= en;
      pcnt_q  <= pcnt_d;
      led_q   <= led_d;
`ifdef GPO_BLINK_POL_EN
      pol_q   <= pol_d;
`endif
    end
  end

  // Shared prescaler/phase keep all blinking channels in lockstep.
  always_comb begin
    tick_c    = (cnt_q == CNT_MAX);
    cnt_d     = tick_c ? '0 : cnt_q + PW'(1);
    phase_d   = tick_c ? phase_q + 4'd1 : phase_q;
    mode_wr_c = csr_we && (csr_a == BASE_ADDR);
    mode_d    = mode_wr_c ? csr_di[MW-1:0] : mode_q;
`ifdef GPO_BLINK_POL_EN
    pol_d     = (csr_we && (csr_a == POL_ADDR)) ? csr_di[NUM_CH-1:0] : pol_q;
`endif
    pcnt_d    = '0;
    led_d     = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      case (mode_q[2*c +: 2])
        2'b00:   led_d[c] = en[c];
        2'b01:   led_d[c] = en[c] & phase_q[3];
        2'b10:   led_d[c] = en[c] & phase_q[1];
        default: led_d[c] = (pcnt_q[c] != 3'd0);
      endcase
      // Edge load wins over tick decrement; a MODE write clears every pulse.
      if (!mode_wr_c && (mode_q[2*c +: 2] == 2'b11)) begin
        if (en[c] && !en_q[c]) begin
          pcnt_d[c] = 3'd4;
        end else if (tick_c && (pcnt_q[c] != 3'd0)) begin
          pcnt_d[c] = pcnt_q[c] - 3'd1;
        end else begin
          pcnt_d[c] = pcnt_q[c];
        end
      end
    end
`ifdef GPO_BLINK_POL_EN
    led_d = led_d ^ pol_q;
`endif
  end

  always_comb begin
    csr_do = 8'h00;
    if (csr_a == BASE_ADDR) begin
      csr_do = 8'(mode_q);
`ifdef GPO_BLINK_POL_EN
    end else if (csr_a == POL_ADDR) begin
      csr_do = 8'(pol_q);
`endif
    end
  end

endmodule

// File: tb/tb_gpo_blink.sv
// Self-checking bench for gpo_blink (TICK_DIV=4, NUM_CH=4), random plus directed scenarios.
module tb_gpo_blink;
  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] csr_a = 5'd0;
  logic [7:0] csr_di = 8'd0;
  logic       csr_we = 1'b0;
  logic [7:0] csr_do;
  logic [3:0] en = 4'd0;
  logic [3:0] led;

  int vectors = 0;
  int miscompares = 0;

  gpo_blink #(.BASE_ADDR(5'h0), .NUM_CH(4), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .csr_a(csr_a), .csr_di(csr_di),
    .csr_we(csr_we), .csr_do(csr_do), .en(en), .led(led)
  );

  always #5 clk = ~clk;

  // Reference model: time since reset gives prescaler/phase; pulses are remaining-tick counts.
  int         cyc = 0;
  logic [7:0] m_mode = 8'h00;
  logic [3:0] m_pol = 4'h0;
  logic [3:0] m_prev = 4'h0;
  int         m_rem [4] = '{0, 0, 0, 0};
  logic [3:0] exp_led = 4'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; m_mode = 8'h00; m_pol = 4'h0; m_prev = 4'h0; exp_led = 4'h0;
      for (int c = 0; c < 4; c++) m_rem[c] = 0;
    end else begin
      int  ph;
      bit  tk, wr;
      logic [3:0] nl;
      ph = (cyc / TD) % 16;
      tk = (cyc % TD) == TD - 1;
      wr = csr_we && csr_a == 5'd0;
      for (int c = 0; c < 4; c++) begin
        int md;
        md = (m_mode >> (2 * c)) & 3;
        case (md)
          0: nl[c] = en[c];
          1: nl[c] = en[c] && (ph >= 8);
          2: nl[c] = en[c] && ((ph % 4) >= 2);
          default: nl[c] = m_rem[c] > 0;
        endcase
        nl[c] = nl[c] ^ m_pol[c];
        if (wr || md != 3) m_rem[c] = 0;
        else if (en[c] && !m_prev[c]) m_rem[c] = 4;
        else if (tk && m_rem[c] > 0) m_rem[c] = m_rem[c] - 1;
      end
      if (wr) m_mode = csr_di;
`ifdef GPO_BLINK_POL_EN
      if (csr_we && csr_a == 5'd1) m_pol = csr_di[3:0];
`endif
      m_prev = en;
      cyc = cyc + 1;
      exp_led = nl;
    end
  end

  task automatic csr_write(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    csr_a = a; csr_di = d; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0; csr_a = 5'd0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (led !== 4'h0) begin miscompares++; $display("FAIL reset_led got=%b want=0000", led); end
    csr_a = 5'd0; #1;
    vectors++;
    if (csr_do !== 8'h00) begin miscompares++; $display("FAIL reset_mode got=%h want=00", csr_do); end
    en = 4'b0101;
    @(negedge clk);
    vectors++;
    if (led !== 4'b0101) begin miscompares++; $display("FAIL steady_led got=%b want=0101", led); end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (led !== 4'h0) begin miscompares++; $display("FAIL async_reset got=%b want=0000", led); end
    en = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_blink;
    logic [3:0] prev;
    int t0, t1;
    en = 4'b0011;
    csr_write(5'd0, 8'b0000_1001);
    repeat (8) @(negedge clk);
    prev = led; t0 = 0; t1 = 0;
    repeat (64) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led) begin miscompares++; $display("FAIL blink_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (led[0] != prev[0]) t0++;
      if (led[1] != prev[1]) t1++;
      prev = led;
    end
    vectors++;
    if (t1 != 8 || t0 != 2) begin miscompares++; $display("FAIL blink_toggles got=%0d/%0d want=8/2", t1, t0); end
  endtask

  task automatic test_pulse;
    int hi;
    en = 4'b0000;
    csr_write(5'd0, 8'hFF);
    @(negedge clk);
    en = 4'b0001; hi = 0;
    repeat (40) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led) begin miscompares++; $display("FAIL pulse_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
      if (led[0]) hi++;
    end
    vectors++;
    if (hi < 13 || hi > 19) begin miscompares++; $display("FAIL pulse_len got=%0d want=13..19", hi); end
    en = 4'b0000; @(negedge clk);
    en = 4'b0001;
    repeat (2 * TD) @(negedge clk);
    en = 4'b0000; @(negedge clk);
    en = 4'b0001;
    repeat (30) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led) begin miscompares++; $display("FAIL retrig_model cyc=%0d got=%b want=%b", cyc, led, exp_led); end
    end
  endtask

  task automatic test_collision;
    int guard;
    en = 4'b0000; @(negedge clk);
    en = 4'b0001; @(negedge clk);
    en = 4'b0000;
    guard = 0;
    while (!(m_rem[0] == 1 && (cyc % TD) == TD - 1) && guard < 100) begin
      @(negedge clk); guard++;
    end
    vectors++;
    if (guard >= 100) begin miscompares++; $display("FAIL collision_wait got=timeout want=pcnt1_tick"); end
    en = 4'b0001;
    repeat (12) begin
      @(negedge clk);
      vectors++;
      if (led[0] !== 1'b1 || led !== exp_led) begin
        miscompares++; $display("FAIL collision_led cyc=%0d got=%b want=%b", cyc, led, exp_led);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_csr_decode;
    csr_write(5'd2, 8'hA5);
    csr_a = 5'd0; #1;
    vectors++;
    if (csr_do !== 8'hFF) begin miscompares++; $display("FAIL mode_unchanged got=%h want=ff", csr_do); end
    for (int a = 2; a < 32; a++) begin
      csr_a = 5'(a); #1;
      vectors++;
      if (csr_do !== 8'h00) begin miscompares++; $display("FAIL read_addr%0d got=%h want=00", a, csr_do); end
    end
    csr_a = 5'd0;
    en = 4'b0000; @(negedge clk);
    en = 4'b0001;
    repeat (3) @(negedge clk);
    csr_a = 5'd0; csr_di = 8'hFF; csr_we = 1'b1;
    @(negedge clk);
    csr_we = 1'b0;
    @(negedge clk);
    vectors++;
    if (led[0] !== 1'b0) begin miscompares++; $display("FAIL mode_wr_clear got=%b want=0", led[0]); end
  endtask

  task automatic test_pol;
    en = 4'b0000;
    csr_write(5'd0, 8'h00);
    csr_write(5'd1, 8'h01);
    csr_a = 5'd1; #1;
`ifdef GPO_BLINK_POL_EN
    vectors++;
    if (csr_do !== 8'h01) begin miscompares++; $display("FAIL pol_read got=%h want=01", csr_do); end
    @(negedge clk);
    vectors++;
    if (led !== 4'b0001) begin miscompares++; $display("FAIL pol_led got=%b want=0001", led); end
`else
    vectors++;
    if (csr_do !== 8'h00) begin miscompares++; $display("FAIL pol_read got=%h want=00", csr_do); end
    @(negedge clk);
    vectors++;
    if (led !== 4'b0000) begin miscompares++; $display("FAIL pol_led got=%b want=0000", led); end
`endif
    csr_a = 5'd0;
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      vectors++;
      if (led !== exp_led) begin miscompares++; $display("FAIL random_model i=%0d got=%b want=%b", i, led, exp_led); end
      csr_a = 5'd0; #1;
      vectors++;
      if (csr_do !== m_mode) begin miscompares++; $display("FAIL random_mode i=%0d got=%h want=%h", i, csr_do, m_mode); end
      if (($urandom % 4) == 0) en = 4'($urandom);
      csr_we = (($urandom % 40) == 0);
      csr_a = 5'($urandom % 3);
      csr_di = 8'($urandom);
    end
    @(negedge clk);
    csr_we = 1'b0;
  endtask

  initial begin
    test_reset;
    test_blink;
    test_pulse;
    test_collision;
    test_csr_decode;
    test_pol;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
